// File: rtl/cfg_loader_pkg.sv
// Shared constants, FSM state type and error-bit indices for the bundle config loader.
package cfg_loader_pkg;

    // Engine register map
    localparam int unsigned A_START       = 0;
    localparam int unsigned A_N_BUNDLES_1 = 1;
    localparam int unsigned N_REG         = 16;

    // Sticky error flag bit positions
    localparam int unsigned ERR_EARLY_LAST = 0;
    localparam int unsigned ERR_NO_LAST    = 1;
    localparam int unsigned ERR_BAD_CMD    = 2;
    localparam int unsigned ERR_READBACK   = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrNb,
        StRbRd,
        StRbWait,
        StWrStart1,
        StWrStart0,
        StFin
    } state_e;

endpackage

// File: rtl/bundle_cfg_loader_if.sv
// Command, bundle stream, engine register port and status signals of the loader.
// master = loader side, slave = environment (DMA, engine, PS) side.
interface bundle_cfg_loader_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned CW             = 16
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [CW-1:0]             cmd_n_bundles;

    logic [AXI_DATA_WIDTH-1:0] s_axis_tdata;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic                      s_axis_tlast;

    logic                      reg_wr_en;
    logic                      reg_wr_ack;
    logic [AXI_ADDR_WIDTH-1:0] reg_wr_addr;
    logic [AXI_DATA_WIDTH-1:0] reg_wr_data;

    logic                      reg_rd_en;
    logic                      reg_rd_ack;
    logic [AXI_ADDR_WIDTH-1:0] reg_rd_addr;
    logic [AXI_DATA_WIDTH-1:0] reg_rd_data;

    logic                      busy;
    logic                      done;
    logic [3:0]                err;

    modport master (
        input  cmd_valid, cmd_n_bundles,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  reg_wr_ack, reg_rd_ack, reg_rd_data,
        output cmd_ready, s_axis_tready,
        output reg_wr_en, reg_wr_addr, reg_wr_data,
        output reg_rd_en, reg_rd_addr,
        output busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_n_bundles,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output reg_wr_ack, reg_rd_ack, reg_rd_data,
        input  cmd_ready, s_axis_tready,
        input  reg_wr_en, reg_wr_addr, reg_wr_data,
        input  reg_rd_en, reg_rd_addr,
        input  busy, done, err
    );

endinterface

// File: rtl/reg_wr_master.sv
// One-entry write holding register: drives en/addr/data steady until ack, and
// reports free (no write pending, or pending write acked this cycle).
module reg_wr_master #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          ack_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o,
    output logic          free_o,
    output logic          done_o
);

    logic          en_q, en_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    // Next-state: a new load wins over ack so back-to-back writes keep en high
    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        data_d = data_q;
        if (load_i) begin
            en_d   = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end else if (en_q && ack_i) begin
            en_d = 1'b0;
        end
    end

    // Holding register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign wr_en_o   = en_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
    // Ack with en low is not a completion
    assign done_o    = en_q && ack_i;
    assign free_o    = !en_q || ack_i;

endmodule

// File: rtl/bundle_cfg_loader.sv
// Bundle config loader: streams DMA bundle words into the engine SRAM window,
// then programs the bundle count and pulses start through the register port.
// Optional feature macro: CFG_READBACK_EN (read back the bundle count before start).
module bundle_cfg_loader #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned CW             = 16,
    parameter int unsigned N_REG          = cfg_loader_pkg::N_REG,
    parameter int unsigned BUNDLE_WORDS   = 32,
    parameter int unsigned MAX_BUNDLES    = 8
) (
    input logic                 clk,
    input logic                 rstn,
    bundle_cfg_loader_if.master bus
);
    import cfg_loader_pkg::*;

    localparam int unsigned     TW           = CW + 8;
    localparam logic [TW-1:0]   BundleWordsW = TW'(BUNDLE_WORDS);
    localparam logic [CW-1:0]   MaxBundlesW  = CW'(MAX_BUNDLES);
    localparam logic [AXI_ADDR_WIDTH-1:0] SramBase = AXI_ADDR_WIDTH'(N_REG);

    state_e        state_q, state_d;
    logic [TW-1:0] total_q, total_d;
    logic [TW-1:0] idx_q, idx_d;
    logic [CW-1:0] nb_q, nb_d;
    logic [3:0]    err_q, err_d;
    logic          issued_q, issued_d;  // register write of current WR_* state issued
    logic          drain_q, drain_d;    // final/aborting word captured, waiting its ack
    logic          abort_q, abort_d;    // stream error: skip count/start writes

    logic                      wr_load, wr_free, wr_done;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic                      axis_ready;
    logic                      cmd_bad;
    logic                      is_last_idx;
    logic [AXI_DATA_WIDTH-1:0] nb_m1_ext;

    assign cmd_bad     = (bus.cmd_n_bundles == '0) || (bus.cmd_n_bundles > MaxBundlesW);
    assign is_last_idx = (idx_q == total_q - TW'(1));
    assign nb_m1_ext   = AXI_DATA_WIDTH'(nb_q - CW'(1));

    // Next-state and write-request decode
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        idx_d      = idx_q;
        nb_d       = nb_q;
        err_d      = err_q;
        issued_d   = issued_q;
        drain_d    = drain_q;
        abort_d    = abort_q;
        wr_load    = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        axis_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    err_d    = '0;
                    nb_d     = bus.cmd_n_bundles;
                    total_d  = TW'(bus.cmd_n_bundles) * BundleWordsW;
                    idx_d    = '0;
                    issued_d = 1'b0;
                    drain_d  = 1'b0;
                    abort_d  = 1'b0;
                    if (cmd_bad) begin
                        err_d[ERR_BAD_CMD] = 1'b1;
                        state_d            = StFin;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end

            StLoad: begin
                wr_addr = SramBase + AXI_ADDR_WIDTH'(idx_q);
                wr_data = bus.s_axis_tdata;
                if (drain_q) begin
                    if (wr_done) begin
                        drain_d = 1'b0;
                        state_d = abort_q ? StFin : StWrNb;
                    end
                end else begin
                    // One-word skid: accept in the ack cycle of the pending write
                    axis_ready = wr_free;
                    if (bus.s_axis_tvalid && wr_free) begin
                        wr_load = 1'b1;
                        idx_d   = idx_q + TW'(1);
                        if (bus.s_axis_tlast && !is_last_idx) begin
                            err_d[ERR_EARLY_LAST] = 1'b1;
                            drain_d               = 1'b1;
                            abort_d               = 1'b1;
                        end else if (is_last_idx && !bus.s_axis_tlast) begin
                            err_d[ERR_NO_LAST] = 1'b1;
                            drain_d            = 1'b1;
                            abort_d            = 1'b1;
                        end else if (is_last_idx) begin
                            drain_d = 1'b1;
                        end
                    end
                end
            end

            StWrNb, StWrStart1, StWrStart0: begin
                if (state_q == StWrNb) begin
                    wr_addr = AXI_ADDR_WIDTH'(A_N_BUNDLES_1);
                    wr_data = nb_m1_ext;
                end else begin
                    wr_addr = AXI_ADDR_WIDTH'(A_START);
                    wr_data = (state_q == StWrStart1) ? AXI_DATA_WIDTH'(1) : '0;
                end
                if (!issued_q) begin
                    if (wr_free) begin
                        wr_load  = 1'b1;
                        issued_d = 1'b1;
                    end
                end else if (wr_done) begin
                    issued_d = 1'b0;
                    if (state_q == StWrNb) begin
`ifdef CFG_READBACK_EN
                        state_d = StRbRd;
`else
                        state_d = StWrStart1;
`endif
                    end else if (state_q == StWrStart1) begin
                        state_d = StWrStart0;
                    end else begin
                        state_d = StFin;
                    end
                end
            end

`ifdef CFG_READBACK_EN
            StRbRd: begin
                state_d = StRbWait;
            end

            StRbWait: begin
                if (bus.reg_rd_ack) begin
                    if (bus.reg_rd_data != nb_m1_ext) begin
                        err_d[ERR_READBACK] = 1'b1;
                        state_d             = StFin;
                    end else begin
                        state_d = StWrStart1;
                    end
                end
            end
`endif

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

`ifndef CFG_READBACK_EN
        err_d[ERR_READBACK] = 1'b0;
`endif
    end

    // FSM and datapath state, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            total_q  <= '0;
            idx_q    <= '0;
            nb_q     <= '0;
            err_q    <= '0;
            issued_q <= 1'b0;
            drain_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            idx_q    <= idx_d;
            nb_q     <= nb_d;
            err_q    <= err_d;
            issued_q <= issued_d;
            drain_q  <= drain_d;
            abort_q  <= abort_d;
        end
    end

    reg_wr_master #(
        .AW (AXI_ADDR_WIDTH),
        .DW (AXI_DATA_WIDTH)
    ) u_reg_wr_master (
        .clk_i     (clk),
        .rst_ni    (rstn),
        .load_i    (wr_load),
        .addr_i    (wr_addr),
        .data_i    (wr_data),
        .ack_i     (bus.reg_wr_ack),
        .wr_en_o   (bus.reg_wr_en),
        .wr_addr_o (bus.reg_wr_addr),
        .wr_data_o (bus.reg_wr_data),
        .free_o    (wr_free),
        .done_o    (wr_done)
    );

    assign bus.cmd_ready     = (state_q == StIdle);
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StFin);
    assign bus.err           = err_q;
    assign bus.s_axis_tready = axis_ready;

`ifdef CFG_READBACK_EN
    assign bus.reg_rd_en   = (state_q == StRbRd);
    assign bus.reg_rd_addr = (state_q == StRbRd) ? AXI_ADDR_WIDTH'(A_N_BUNDLES_1) : '0;
`else
    logic unused_rd;
    assign unused_rd       = ^{bus.reg_rd_ack, bus.reg_rd_data};
    assign bus.reg_rd_en   = 1'b0;
    assign bus.reg_rd_addr = '0;
`endif

endmodule

// File: tb/tb_bundle_cfg_loader.sv
// Self-checking bench for bundle_cfg_loader: directed and randomized loads checked
// against a list-level model of the expected register write sequence and error flags.
module tb_bundle_cfg_loader;

`ifdef CFG_READBACK_EN
    localparam bit Readback = 1'b1;
`else
    localparam bit Readback = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    bundle_cfg_loader_if bus ();

    bundle_cfg_loader dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [63:0] wr_log[$];
    logic [63:0] exp_q[$];
    logic [31:0] wdat[$];
    bit          wlast[$];
    int          ack_delay = 0;
    bit          spur_ack  = 1'b0;
    int          done_cnt  = 0;
    int          rb_value  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register-port responder, write logger and per-cycle protocol checks
    initial begin
        int          cnt;
        bit          hold;
        bit          rb_pend;
        logic [31:0] pa, pd;
        cnt = 0; hold = 1'b0; rb_pend = 1'b0; pa = '0; pd = '0;
        bus.reg_wr_ack  = 1'b0;
        bus.reg_rd_ack  = 1'b0;
        bus.reg_rd_data = '0;
        forever begin
            @(negedge clk);
            if (hold && bus.reg_wr_en) begin
                check("wr_addr_stable", bus.reg_wr_addr, pa);
                check("wr_data_stable", bus.reg_wr_data, pd);
            end
            if (bus.reg_wr_ack) begin
                bus.reg_wr_ack = 1'b0;
                cnt = 0;
            end
            if (!bus.reg_wr_en) cnt = 0;
            if (bus.reg_wr_en) begin
                if (cnt >= ack_delay) begin
                    bus.reg_wr_ack = 1'b1;
                    wr_log.push_back({bus.reg_wr_addr, bus.reg_wr_data});
                end else begin
                    cnt++;
                end
            end else if (spur_ack) begin
                bus.reg_wr_ack = 1'b1;
            end
            hold = bus.reg_wr_en && !bus.reg_wr_ack;
            pa   = bus.reg_wr_addr;
            pd   = bus.reg_wr_data;

            bus.reg_rd_ack = 1'b0;
            if (rb_pend) begin
                bus.reg_rd_ack  = 1'b1;
                bus.reg_rd_data = rb_value;
                rb_pend = 1'b0;
            end
            if (bus.reg_rd_en) rb_pend = 1'b1;

            if (bus.done) done_cnt++;
            #1;
            if (bus.reg_wr_en && !bus.reg_wr_ack) check("tready_blocked", bus.s_axis_tready, 0);
        end
    end

    task automatic make_words(input int count, input int last_idx, input bit seq);
        wdat.delete();
        wlast.delete();
        for (int i = 0; i < count; i++) begin
            wdat.push_back(seq ? 32'(i) : $urandom);
            wlast.push_back(i == last_idx);
        end
    endtask

    // Reference: expected write list and error flags from the load rules
    task automatic build_expected(input int n, input int rbv, output logic [3:0] e);
        int total;
        exp_q.delete();
        e = 4'b0000;
        if (n == 0 || n > 8) begin
            e = 4'b0100;
            return;
        end
        total = n * 32;
        for (int i = 0; i < wdat.size(); i++) begin
            exp_q.push_back({32'(16 + i), wdat[i]});
            if (wlast[i] && i < total - 1) begin
                e = 4'b0001;
                return;
            end
            if (i == total - 1) begin
                if (!wlast[i]) begin
                    e = 4'b0010;
                    return;
                end
                exp_q.push_back({32'd1, 32'(n - 1)});
                if (Readback && rbv != n - 1) begin
                    e = 4'b1000;
                    return;
                end
                exp_q.push_back({32'd0, 32'd1});
                exp_q.push_back({32'd0, 32'd0});
                return;
            end
        end
    endtask

    task automatic send_cmd(input int n);
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid     = 1'b1;
        bus.cmd_n_bundles = 16'(n);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_words(input bit toggle);
        bit ok;
        for (int i = 0; i < wdat.size(); i++) begin
            if (toggle && ($urandom_range(0, 1) == 1)) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = wdat[i];
            bus.s_axis_tlast  = wlast[i];
            ok = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                #2;
                if (bus.s_axis_tready) begin
                    @(posedge clk);
                    #1;
                    ok = 1'b1;
                end
            end
            if (!ok) begin
                check("tready_timeout", 0, 1);
                break;
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int c = 0; c < 2000 && done_cnt == d0; c++) @(negedge clk);
        @(negedge clk);
        check({tag, "_done_low"}, bus.done, 0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic compare_log(input string tag, input logic [3:0] e);
        check({tag, "_wr_count"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_q[i]);
        check({tag, "_err"}, bus.err, e);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    endtask

    task automatic run_load(input string tag, input int n, input int count, input int last_idx,
                            input bit seq, input bit toggle, input int delay, input int rbv);
        logic [3:0] e;
        int         d0;
        ack_delay = delay;
        rb_value  = rbv;
        make_words(count, last_idx, seq);
        build_expected(n, rbv, e);
        wr_log.delete();
        d0 = done_cnt;
        send_cmd(n);
        send_words(toggle);
        wait_done(tag, d0);
        compare_log(tag, e);
    endtask

    initial begin
        int n, total, mode, k, d0;
        rstn              = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_n_bundles = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_wr_en", bus.reg_wr_en, 0);
        check("rst_tready", bus.s_axis_tready, 0);
        check("rst_rd_en", bus.reg_rd_en, 0);
        check("rst_rd_addr", bus.reg_rd_addr, 0);

        // Ack while no write is pending must be ignored
        wr_log.delete();
        spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_no_wr", wr_log.size(), 0);
        check("spur_busy", bus.busy, 0);

        run_load("norm2", 2, 64, 63, 1'b1, 1'b0, 0, 1);
        run_load("slow2", 2, 64, 63, 1'b1, 1'b1, 3, 1);
        run_load("early", 1, 11, 10, 1'b0, 1'b0, 0, 0);
        run_load("nolast", 1, 32, -1, 1'b0, 1'b1, 1, 0);

        // Bad commands: error, no writes, done one cycle after accept
        for (int b = 0; b < 2; b++) begin
            wr_log.delete();
            d0 = done_cnt;
            send_cmd(b == 0 ? 0 : 9);
            @(negedge clk);
            check("bad_done_next", bus.done, 1);
            @(negedge clk);
            check("bad_done_low", bus.done, 0);
            check("bad_done_pulses", done_cnt - d0, 1);
            check("bad_err", bus.err, 4'b0100);
            check("bad_no_wr", wr_log.size(), 0);
        end

        // Reset mid-load at word 20, then a fresh load starts at the window base
        ack_delay = 0;
        make_words(21, -1, 1'b0);
        send_cmd(1);
        send_words(1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_wr_en", bus.reg_wr_en, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_cmd_ready", bus.cmd_ready, 1);
        run_load("reload", 1, 32, 31, 1'b0, 1'b0, 0, 0);

        if (Readback) begin
            run_load("rb_bad", 2, 64, 63, 1'b0, 1'b0, 0, 5);
            run_load("rb_ok", 2, 64, 63, 1'b0, 1'b0, 1, 1);
        end

        // Randomized loads: normal, early tlast or missing tlast
        for (int r = 0; r < 5; r++) begin
            n     = $urandom_range(1, 2);
            total = n * 32;
            mode  = $urandom_range(0, 2);
            if (mode == 0) begin
                run_load($sformatf("rnd%0d", r), n, total, total - 1, 1'b0,
                         1'($urandom_range(0, 1)), $urandom_range(0, 2), n - 1);
            end else if (mode == 1) begin
                k = $urandom_range(0, total - 2);
                run_load($sformatf("rnd%0d", r), n, k + 1, k, 1'b0,
                         1'($urandom_range(0, 1)), $urandom_range(0, 2), n - 1);
            end else begin
                run_load($sformatf("rnd%0d", r), n, total, -1, 1'b0,
                         1'($urandom_range(0, 1)), $urandom_range(0, 2), n - 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
